dataint_ecc_hamming_decode_secded_pipe: RTL and testbench
=========================================================

Name: dataint_ecc_hamming_decode_secded_pipe

Overview:
Multi-lane, pipelined SECDED Hamming decoder with valid/ready flow control. Each beat carries LANES independent codewords. Each codeword is checked, single-bit errors are corrected, and double-bit errors are flagged. The block keeps saturating error counters and a sticky first-error capture for status/CSR logic. It sits between ECC-protected storage (SRAM/FIFO read side) and the consumer, and tolerates consumer backpressure.

Parameters:
- WIDTH, 32: data bits per lane; must be >=4.
- LANES, 2: codewords per beat; must be >=1.
- CNT_WIDTH, 16: width of each error counter.
- Derived P = $clog2(WIDTH+$clog2(WIDTH)+1): Hamming parity bits.
- Derived CW = WIDTH+P+1: codeword width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; asynchronous, active-high.
- i_valid  in  1  input beat valid.
- o_ready  out  1  block accepts a beat when i_valid&o_ready.
- i_hamming_data  in  LANES*CW  lane k occupies [k*CW +: CW].
- o_valid  out  1  output beat valid.
- i_ready  in  1  consumer accepts a beat when o_valid&i_ready.
- o_data  out  LANES*WIDTH  corrected data; lane k at [k*WIDTH +: WIDTH].
- o_single_err  out  LANES  per-lane corrected single error, qualified by o_valid.
- o_double_err  out  LANES  per-lane uncorrectable error, qualified by o_valid.
- o_syndrome  out  LANES*P  per-lane syndrome, qualified by o_valid.
- i_clr_counts  in  1  synchronous clear of counters and sticky capture.
- o_sec_count  out  CNT_WIDTH  total corrected single errors, saturating.
- o_ded_count  out  CNT_WIDTH  total double errors, saturating.
- o_first_err_valid  out  1  sticky; set when the first errored beat is accepted.
- o_first_err_lane  out  $clog2(LANES) (min 1)  lowest errored lane of that first beat.
- o_first_err_syndrome  out  P  syndrome of that lane.

Behaviour:
- Codeword layout: index i (0..CW-2) is Hamming position i+1. Parity bits sit at positions 2^j. Data bit d occupies the d-th non-power-of-two position in ascending order. Index CW-1 is the overall even parity over indices 0..CW-2.
- Syndrome bit j = XOR of all indices 0..CW-2 whose position has bit j set. Parity mismatch pm = XOR of all CW bits.
- Classification:
  - pm=1, syn!=0: single error; flip index syn-1. If syn-1 >= CW-1 (out of range), treat as double error instead.
  - pm=1, syn=0: single error in the overall parity bit; data is unaffected.
  - pm=0, syn!=0: double error; data is output uncorrected.
  - pm=0, syn=0: clean.
- Pipeline:
  - Stage 1 registers the codewords, syndromes and pm.
  - Stage 2 registers the corrected data and flags.
  - Latency is 2 cycles from input handshake to o_valid when there is no backpressure. Throughput is 1 beat/cycle.
- Flow control:
  - s2_en = ~s2_valid | i_ready.
  - s1_en = ~s1_valid | s2_en.
  - o_ready = s1_en (combinational from i_ready).
  - Data registers load only when their stage is enabled. o_data and flags hold stable while o_valid&~i_ready.
- Counters update on the output handshake:
  - o_sec_count += popcount(o_single_err).
  - o_ded_count += popcount(o_double_err).
  - Each counter saturates at all-ones and never wraps.
  - i_clr_counts in the same cycle as an increment wins: the counter goes to 0.
- Sticky capture loads on the first output handshake with any error flag while o_first_err_valid=0. It then holds until i_clr_counts. Clear and capture in the same cycle: clear wins.
- Reset (i_rst, async) sets to 0: s1_valid, s2_valid, o_valid, all flags, o_syndrome, o_data, counters and the sticky fields. o_ready is 1 after reset. A reset mid-operation discards in-flight beats with no partial output.

Test Plan:
- WIDTH=4, LANES=1: input 8'h55 (data 4'hB, clean) -> 2 cycles later o_valid=1, o_data=4'hB, flags 0, syndrome 0, counters unchanged.
- Input 8'h45 (index 4 flipped) -> o_data=4'hB, o_single_err=1, o_syndrome=5, o_sec_count=1, first_err captured with lane 0, syndrome 5.
- Input 8'hD5 (overall parity flipped) -> o_data=4'hB, o_single_err=1, o_syndrome=0. Input 8'h50 (indices 0 and 2 flipped) -> o_double_err=1, o_data=4'hA, o_ded_count increments.
- Back-to-back stream of 8 beats with i_ready toggled 1,0,0,1... -> no beat lost or duplicated, in-order output, o_data stable during stalls, o_ready drops only when both stages are full and stalled.
- LANES=2, lane0 clean and lane1 double error in one beat -> o_single_err=2'b00, o_double_err=2'b10, first_err_lane=1. CNT_WIDTH=2 with 5 single errors -> o_sec_count saturates at 3. Clear asserted with a concurrent error -> counter reads 0.
- i_rst asserted with both stages full -> o_valid and counters go to 0 immediately (async). After release, o_ready=1 and the next beat emerges after 2 cycles.

Source files
------------

// File: rtl/dataint_ecc_hamming_decode_secded_pipe.sv
// ---------------------------------------------------------------------------
// dataint_ecc_hamming_decode_secded_pipe
//
// Two-stage pipelined SECDED Hamming decoder for LANES independent codewords
// per beat, with valid/ready flow control on both sides.
//
// Codeword layout, per lane of CW bits:
//   index i (0..CW-2)  -> Hamming position i+1
//                         parity bits at positions 2^j
//                         data bits fill the remaining positions in ascending order
//   index CW-1         -> overall even parity over indices 0..CW-2
//
// Stage 1 registers the raw codewords, syndromes and overall parity mismatch.
// Stage 2 registers the corrected data, per-lane error flags and syndromes.
// Saturating error counters and a sticky first-error capture update on the
// output handshake.
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_valid / o_ready       input beat handshake
//   i_hamming_data          LANES codewords, lane k at [k*CW +: CW]
//   o_valid / i_ready       output beat handshake
//   o_data                  corrected data, lane k at [k*WIDTH +: WIDTH]
//   o_single_err            per-lane corrected single error (qualified by o_valid)
//   o_double_err            per-lane uncorrectable error (qualified by o_valid)
//   o_syndrome              per-lane syndrome, lane k at [k*P +: P]
//   i_clr_counts            synchronous clear of counters and sticky capture
//   o_sec_count             saturating count of corrected single errors
//   o_ded_count             saturating count of double errors
//   o_first_err_valid       sticky: an errored beat has been delivered
//   o_first_err_lane        lowest errored lane of that first beat
//   o_first_err_syndrome    syndrome of that lane
// ---------------------------------------------------------------------------
module dataint_ecc_hamming_decode_secded_pipe #(
    parameter int  WIDTH     = 32,
    parameter int  LANES     = 2,
    parameter int  CNT_WIDTH = 16,
    localparam int P         = $clog2(WIDTH + $clog2(WIDTH) + 1),
    localparam int CW        = WIDTH + P + 1,
    localparam int LW        = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [LANES*CW-1:0]      i_hamming_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [LANES*WIDTH-1:0]   o_data,
    output logic [LANES-1:0]         o_single_err,
    output logic [LANES-1:0]         o_double_err,
    output logic [LANES*P-1:0]       o_syndrome,
    input  logic                     i_clr_counts,
    output logic [CNT_WIDTH-1:0]     o_sec_count,
    output logic [CNT_WIDTH-1:0]     o_ded_count,
    output logic                     o_first_err_valid,
    output logic [LW-1:0]            o_first_err_lane,
    output logic [P-1:0]             o_first_err_syndrome
);

    // Width of a per-beat error popcount and of the saturating adder.
    localparam int PCW = $clog2(LANES + 1);
    localparam int SW  = ((CNT_WIDTH > PCW) ? CNT_WIDTH : PCW) + 1;

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------

    // Syndrome bit j is the XOR of every covered bit whose position has bit j set.
    function automatic logic [P-1:0] calc_syndrome(input logic [CW-1:0] cw);
        logic [P-1:0]  syn;
        logic [31:0]   pos;
        syn = '0;
        for (int i = 0; i < CW - 1; i++) begin
            pos = 32'(i + 1);
            for (int j = 0; j < P; j++) begin
                syn[j] = syn[j] ^ (cw[i] & pos[j]);
            end
        end
        return syn;
    endfunction

    // Gather data bits from the non-power-of-two positions. Bits are shifted in
    // from the top so the lowest such position ends up in data bit 0.
    function automatic logic [WIDTH-1:0] extract_data(input logic [CW-1:0] cw);
        logic [WIDTH-1:0] data;
        logic [31:0]      pos;
        data = '0;
        for (int i = 0; i < CW - 1; i++) begin
            pos = 32'(i + 1);
            if ((pos & (pos - 32'd1)) != 32'd0) begin
                data = {cw[i], data[WIDTH-1:1]};
            end else begin
                data = data;
            end
        end
        return data;
    endfunction

    // Number of set bits in a per-lane flag vector.
    function automatic logic [PCW-1:0] popcount(input logic [LANES-1:0] v);
        logic [PCW-1:0] cnt;
        cnt = '0;
        for (int k = 0; k < LANES; k++) begin
            cnt = cnt + PCW'(v[k]);
        end
        return cnt;
    endfunction

    // Add and clamp at all-ones; any carry out of CNT_WIDTH means saturation.
    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [PCW-1:0]       b);
        logic [SW-1:0] sum;
        sum = SW'(a) + SW'(b);
        if (sum[SW-1:CNT_WIDTH] != '0) begin
            return '1;
        end else begin
            return sum[CNT_WIDTH-1:0];
        end
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic                     s1_valid_q, s1_valid_d;
    logic [LANES*CW-1:0]      s1_cw_q, s1_cw_d;
    logic [LANES*P-1:0]       s1_syn_q, s1_syn_d;
    logic [LANES-1:0]         s1_pm_q, s1_pm_d;

    logic                     s2_valid_q, s2_valid_d;
    logic [LANES*WIDTH-1:0]   s2_data_q, s2_data_d;
    logic [LANES-1:0]         s2_single_q, s2_single_d;
    logic [LANES-1:0]         s2_double_q, s2_double_d;
    logic [LANES*P-1:0]       s2_syn_q, s2_syn_d;

    logic [CNT_WIDTH-1:0]     sec_count_q, sec_count_d;
    logic [CNT_WIDTH-1:0]     ded_count_q, ded_count_d;
    logic                     first_valid_q, first_valid_d;
    logic [LW-1:0]            first_lane_q, first_lane_d;
    logic [P-1:0]             first_syn_q, first_syn_d;

    logic                     s1_en_s;
    logic                     s2_en_s;
    logic                     out_hs_s;

    // Each stage may load when it is empty or when its content moves on.
    assign s2_en_s  = ~s2_valid_q | i_ready;
    assign s1_en_s  = ~s1_valid_q | s2_en_s;
    assign out_hs_s = s2_valid_q & i_ready;

    // Stage 1 next state: capture codewords, syndromes and parity mismatch.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_cw_d    = s1_cw_q;
        s1_syn_d   = s1_syn_q;
        s1_pm_d    = s1_pm_q;
        if (s1_en_s) begin
            s1_valid_d = i_valid;
            if (i_valid) begin
                s1_cw_d = i_hamming_data;
                for (int k = 0; k < LANES; k++) begin
                    s1_syn_d[k*P +: P] = calc_syndrome(i_hamming_data[k*CW +: CW]);
                    s1_pm_d[k]         = ^i_hamming_data[k*CW +: CW];
                end
            end else begin
                s1_cw_d = s1_cw_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage 2 next state: classify each lane, correct in-range single errors.
    always_comb begin : s2_next_comb
        logic [CW-1:0]          lane_cw;
        logic [P-1:0]           lane_syn;
        logic                   syn_nz;
        logic                   in_range;
        logic                   fix_en;
        logic [LANES*WIDTH-1:0] data_c;
        logic [LANES-1:0]       single_c;
        logic [LANES-1:0]       double_c;

        data_c   = '0;
        single_c = '0;
        double_c = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_cw  = s1_cw_q[k*CW +: CW];
            lane_syn = s1_syn_q[k*P +: P];
            syn_nz   = |lane_syn;
            // A syndrome pointing past the last covered index cannot be a
            // single error; it is reported as uncorrectable.
            in_range = (32'(lane_syn) < 32'(CW));
            fix_en   = s1_pm_q[k] & syn_nz & in_range;
            for (int i = 0; i < CW - 1; i++) begin
                lane_cw[i] = lane_cw[i] ^ (fix_en & (32'(lane_syn) == 32'(i + 1)));
            end
            data_c[k*WIDTH +: WIDTH] = extract_data(lane_cw);
            // pm with zero syndrome is an error in the overall parity bit only.
            single_c[k] = s1_pm_q[k] & (~syn_nz | in_range);
            double_c[k] = syn_nz & (~s1_pm_q[k] | ~in_range);
        end

        s2_valid_d  = s2_valid_q;
        s2_data_d   = s2_data_q;
        s2_single_d = s2_single_q;
        s2_double_d = s2_double_q;
        s2_syn_d    = s2_syn_q;
        if (s2_en_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d   = data_c;
                s2_single_d = single_c;
                s2_double_d = double_c;
                s2_syn_d    = s1_syn_q;
            end else begin
                s2_data_d = s2_data_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Counters and sticky first-error capture; clear wins over any update.
    always_comb begin : status_next_comb
        logic [LANES-1:0] err_any;
        logic [LW-1:0]    cap_lane;
        logic [P-1:0]     cap_syn;

        err_any  = s2_single_q | s2_double_q;
        cap_lane = '0;
        cap_syn  = '0;
        // Walk downward so the lowest errored lane is the one left selected.
        for (int k = LANES - 1; k >= 0; k--) begin
            if (err_any[k]) begin
                cap_lane = LW'(k);
                cap_syn  = s2_syn_q[k*P +: P];
            end else begin
                cap_lane = cap_lane;
            end
        end

        sec_count_d   = sec_count_q;
        ded_count_d   = ded_count_q;
        first_valid_d = first_valid_q;
        first_lane_d  = first_lane_q;
        first_syn_d   = first_syn_q;
        if (i_clr_counts) begin
            sec_count_d   = '0;
            ded_count_d   = '0;
            first_valid_d = 1'b0;
            first_lane_d  = '0;
            first_syn_d   = '0;
        end else if (out_hs_s) begin
            sec_count_d = sat_add(sec_count_q, popcount(s2_single_q));
            ded_count_d = sat_add(ded_count_q, popcount(s2_double_q));
            if (~first_valid_q && (|err_any)) begin
                first_valid_d = 1'b1;
                first_lane_d  = cap_lane;
                first_syn_d   = cap_syn;
            end else begin
                first_valid_d = first_valid_q;
            end
        end else begin
            sec_count_d = sec_count_q;
        end
    end

    // All state flops; reset empties the pipeline and clears status.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid_q    <= 1'b0;
            s1_cw_q       <= '0;
            s1_syn_q      <= '0;
            s1_pm_q       <= '0;
            s2_valid_q    <= 1'b0;
            s2_data_q     <= '0;
            s2_single_q   <= '0;
            s2_double_q   <= '0;
            s2_syn_q      <= '0;
            sec_count_q   <= '0;
            ded_count_q   <= '0;
            first_valid_q <= 1'b0;
            first_lane_q  <= '0;
            first_syn_q   <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_cw_q       <= s1_cw_d;
            s1_syn_q      <= s1_syn_d;
            s1_pm_q       <= s1_pm_d;
            s2_valid_q    <= s2_valid_d;
            s2_data_q     <= s2_data_d;
            s2_single_q   <= s2_single_d;
            s2_double_q   <= s2_double_d;
            s2_syn_q      <= s2_syn_d;
            sec_count_q   <= sec_count_d;
            ded_count_q   <= ded_count_d;
            first_valid_q <= first_valid_d;
            first_lane_q  <= first_lane_d;
            first_syn_q   <= first_syn_d;
        end
    end

    assign o_ready              = s1_en_s;
    assign o_valid              = s2_valid_q;
    assign o_data               = s2_data_q;
    assign o_single_err         = s2_single_q;
    assign o_double_err         = s2_double_q;
    assign o_syndrome           = s2_syn_q;
    assign o_sec_count          = sec_count_q;
    assign o_ded_count          = ded_count_q;
    assign o_first_err_valid    = first_valid_q;
    assign o_first_err_lane     = first_lane_q;
    assign o_first_err_syndrome = first_syn_q;

endmodule

// File: tb/tb_dataint_ecc_hamming_decode_secded_pipe.sv
// ---------------------------------------------------------------------------
// Testbench for dataint_ecc_hamming_decode_secded_pipe.
// Instance A: WIDTH=4, LANES=2, CNT_WIDTH=2 (8-bit codewords per lane).
// Instance B: WIDTH=8, LANES=1, CNT_WIDTH=4 (13-bit codewords, syndrome range
// boundary).
// ---------------------------------------------------------------------------
module tb_dataint_ecc_hamming_decode_secded_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance A signals
    logic        a_valid, a_o_ready, a_o_valid, a_ready, a_clr;
    logic [15:0] a_cw;
    logic [7:0]  a_data;
    logic [1:0]  a_single, a_double;
    logic [5:0]  a_syn;
    logic [1:0]  a_sec, a_ded;
    logic        a_fv;
    logic [0:0]  a_fl;
    logic [2:0]  a_fs;

    // Instance B signals
    logic        b_valid, b_o_ready, b_o_valid, b_ready, b_clr;
    logic [12:0] b_cw;
    logic [7:0]  b_data;
    logic [0:0]  b_single, b_double;
    logic [3:0]  b_syn;
    logic [3:0]  b_sec, b_ded;
    logic        b_fv;
    logic [0:0]  b_fl;
    logic [3:0]  b_fs;

    dataint_ecc_hamming_decode_secded_pipe #(.WIDTH(4), .LANES(2), .CNT_WIDTH(2)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_valid(a_valid), .o_ready(a_o_ready),
        .i_hamming_data(a_cw), .o_valid(a_o_valid), .i_ready(a_ready),
        .o_data(a_data), .o_single_err(a_single), .o_double_err(a_double),
        .o_syndrome(a_syn), .i_clr_counts(a_clr), .o_sec_count(a_sec),
        .o_ded_count(a_ded), .o_first_err_valid(a_fv), .o_first_err_lane(a_fl),
        .o_first_err_syndrome(a_fs)
    );

    dataint_ecc_hamming_decode_secded_pipe #(.WIDTH(8), .LANES(1), .CNT_WIDTH(4)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_valid(b_valid), .o_ready(b_o_ready),
        .i_hamming_data(b_cw), .o_valid(b_o_valid), .i_ready(b_ready),
        .o_data(b_data), .o_single_err(b_single), .o_double_err(b_double),
        .o_syndrome(b_syn), .i_clr_counts(b_clr), .o_sec_count(b_sec),
        .o_ded_count(b_ded), .o_first_err_valid(b_fv), .o_first_err_lane(b_fl),
        .o_first_err_syndrome(b_fs)
    );

    typedef struct {
        logic [15:0] cw;
        logic [7:0]  data;
        logic [1:0]  single;
        logic [1:0]  dbl;
        logic [5:0]  syn;
        logic [1:0]  sec;
        logic [1:0]  ded;
        logic        fv;
        logic        fl;
        logic [2:0]  fs;
    } vec_t;

    vec_t vecs [8];

    int total = 0;
    int bad   = 0;

    // Clean 4-bit-data codewords and their data values.
    logic [7:0] clean_cw [6] = '{8'h55, 8'h2D, 8'h00, 8'hFF, 8'hD2, 8'hAA};
    logic [3:0] clean_d  [6] = '{4'hB, 4'h5, 4'h0, 4'hF, 4'hA, 4'h4};

    // Instance B directed vectors (lane of 13 bits).
    logic [12:0] bcw  [6] = '{13'h0000, 13'h0800, 13'h0004, 13'h0014, 13'h0089, 13'h008C};
    logic [7:0]  bdat [6] = '{8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h01};
    logic        bsgl [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        bdbl [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0]  bsyn [6] = '{4'd0, 4'd12, 4'd3, 4'd6, 4'd13, 4'd15};

    task automatic check(input string name, input int id, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, id, act, exp);
        end
    endtask

    function automatic int l1_idx(input int b);
        return (b + (b / 6) + 3) % 6;
    endfunction

    function automatic logic [15:0] stream_cw(input int b);
        return {clean_cw[l1_idx(b)], clean_cw[b % 6]};
    endfunction

    function automatic logic [7:0] stream_data(input int b);
        return {clean_d[l1_idx(b)], clean_d[b % 6]};
    endfunction

    // Send one beat with i_ready high, check latency, outputs, then status.
    task automatic apply_vec(input vec_t v, input int id);
        int n;
        check("in_ready", id, 32'(a_o_ready), 32'd1);
        a_valid = 1'b1;
        a_cw    = v.cw;
        @(posedge clk); #1;
        a_valid = 1'b0;
        n = 1;
        while (!a_o_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", id, 32'(n), 32'd2);
        check("data",    id, 32'(a_data),   32'(v.data));
        check("single",  id, 32'(a_single), 32'(v.single));
        check("double",  id, 32'(a_double), 32'(v.dbl));
        check("syn",     id, 32'(a_syn),    32'(v.syn));
        @(posedge clk); #1;
        check("drained", id, 32'(a_o_valid), 32'd0);
        check("sec",     id, 32'(a_sec), 32'(v.sec));
        check("ded",     id, 32'(a_ded), 32'(v.ded));
        check("fv",      id, 32'(a_fv),  32'(v.fv));
        check("fl",      id, 32'(a_fl),  32'(v.fl));
        check("fs",      id, 32'(a_fs),  32'(v.fs));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         b_in, b_out, cyc, occ;
        logic       stall;
        logic [7:0] held;
        logic [3:0] rdy_pat;

        //           cw        data   single dbl    syn    sec   ded   fv    fl    fs
        vecs[0] = '{16'h5555, 8'hBB, 2'b00, 2'b00, 6'h00, 2'd0, 2'd0, 1'b0, 1'b0, 3'd0};
        vecs[1] = '{16'h2D55, 8'h5B, 2'b00, 2'b00, 6'h00, 2'd0, 2'd0, 1'b0, 1'b0, 3'd0};
        vecs[2] = '{16'h5545, 8'hBB, 2'b01, 2'b00, 6'h05, 2'd1, 2'd0, 1'b1, 1'b0, 3'd5};
        vecs[3] = '{16'hD555, 8'hBB, 2'b10, 2'b00, 6'h00, 2'd2, 2'd0, 1'b1, 1'b0, 3'd5};
        vecs[4] = '{16'h502D, 8'hA5, 2'b00, 2'b10, 6'h10, 2'd2, 2'd1, 1'b1, 1'b0, 3'd5};
        vecs[5] = '{16'h4545, 8'hBB, 2'b11, 2'b00, 6'h2D, 2'd3, 2'd1, 1'b1, 1'b0, 3'd5};
        vecs[6] = '{16'h5050, 8'hAA, 2'b00, 2'b11, 6'h12, 2'd3, 2'd3, 1'b1, 1'b0, 3'd5};
        vecs[7] = '{16'h5045, 8'hAB, 2'b01, 2'b10, 6'h15, 2'd3, 2'd3, 1'b1, 1'b0, 3'd5};

        rst = 1'b1;
        a_valid = 1'b0; a_cw = 16'h0000; a_ready = 1'b1; a_clr = 1'b0;
        b_valid = 1'b0; b_cw = 13'h0000; b_ready = 1'b1; b_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ovalid", 0, 32'(a_o_valid), 32'd0);
        check("rst_oready", 0, 32'(a_o_ready), 32'd1);
        check("rst_data",   0, 32'(a_data),    32'd0);
        check("rst_flags",  0, 32'({a_single, a_double}), 32'd0);
        check("rst_syn",    0, 32'(a_syn),     32'd0);
        check("rst_counts", 0, 32'({a_sec, a_ded}), 32'd0);
        check("rst_sticky", 0, 32'({a_fv, a_fl, a_fs}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven single beats.
        for (int i = 0; i < 8; i++) begin
            apply_vec(vecs[i], i);
        end

        // Clear with no traffic.
        a_clr = 1'b1;
        @(posedge clk); #1;
        a_clr = 1'b0;
        check("clr_counts", 0, 32'({a_sec, a_ded}), 32'd0);
        check("clr_sticky", 0, 32'({a_fv, a_fl, a_fs}), 32'd0);

        // Lane 0 clean, lane 1 double: first error captured on lane 1.
        apply_vec('{16'h5055, 8'hAB, 2'b00, 2'b10, 6'h10, 2'd0, 2'd1, 1'b1, 1'b1, 3'd2}, 100);

        // Clear in the same cycle as an errored output handshake.
        a_valid = 1'b1;
        a_cw    = 16'h5545;
        @(posedge clk); #1;
        a_valid = 1'b0;
        @(posedge clk); #1;
        check("clrhs_ovalid", 0, 32'(a_o_valid), 32'd1);
        check("clrhs_single", 0, 32'(a_single),  32'd1);
        a_clr = 1'b1;
        @(posedge clk); #1;
        a_clr = 1'b0;
        check("clrhs_sec",    0, 32'(a_sec), 32'd0);
        check("clrhs_ded",    0, 32'(a_ded), 32'd0);
        check("clrhs_sticky", 0, 32'({a_fv, a_fl, a_fs}), 32'd0);

        apply_vec('{16'h5545, 8'hBB, 2'b01, 2'b00, 6'h05, 2'd1, 2'd0, 1'b1, 1'b0, 3'd5}, 101);

        // Streaming with i_ready pattern 1,0,0,1 repeating.
        rdy_pat = 4'b1001;
        b_in = 0; b_out = 0; cyc = 0; stall = 1'b0; held = 8'h00;
        while (b_out < 8 && cyc < 200) begin
            a_ready = rdy_pat[2'(cyc % 4)];
            a_valid = (b_in < 8);
            a_cw    = stream_cw(b_in);
            @(negedge clk);
            occ = b_in - b_out;
            check("stream_oready", cyc, 32'(a_o_ready),
                  (occ == 2 && !a_ready) ? 32'd0 : 32'd1);
            if (stall) begin
                check("hold_valid", cyc, 32'(a_o_valid), 32'd1);
                check("hold_data",  cyc, 32'(a_data),    32'(held));
            end
            if (a_o_valid && a_ready) begin
                check("stream_data", b_out, 32'(a_data), 32'(stream_data(b_out)));
                b_out++;
                stall = 1'b0;
            end else if (a_o_valid) begin
                stall = 1'b1;
                held  = a_data;
            end else begin
                stall = 1'b0;
            end
            if (a_valid && a_o_ready) begin
                b_in++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("stream_out_cnt", 0, 32'(b_out), 32'd8);
        check("stream_in_cnt",  0, 32'(b_in),  32'd8);
        a_valid = 1'b0;
        a_ready = 1'b1;
        @(posedge clk); #1;
        check("stream_idle", 0, 32'(a_o_valid), 32'd0);
        check("stream_sec",  0, 32'(a_sec),     32'd1);

        // Fill both stages under backpressure, then reset asynchronously.
        a_ready = 1'b0;
        a_valid = 1'b1;
        a_cw    = 16'h5555;
        @(posedge clk); #1;
        a_cw    = 16'h2D2D;
        @(posedge clk); #1;
        a_valid = 1'b0;
        check("full_ovalid", 0, 32'(a_o_valid), 32'd1);
        check("full_oready", 0, 32'(a_o_ready), 32'd0);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check("arst_ovalid", 0, 32'(a_o_valid), 32'd0);
        check("arst_counts", 0, 32'({a_sec, a_ded}), 32'd0);
        check("arst_sticky", 0, 32'(a_fv), 32'd0);
        check("arst_data",   0, 32'(a_data), 32'd0);
        check("arst_oready", 0, 32'(a_o_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        a_ready = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle0", 0, 32'(a_o_valid), 32'd0);
        @(posedge clk); #1;
        check("post_rst_idle1", 0, 32'(a_o_valid), 32'd0);
        apply_vec('{16'h2D55, 8'h5B, 2'b00, 2'b00, 6'h00, 2'd0, 2'd0, 1'b0, 1'b0, 3'd0}, 200);

        // Instance B: syndrome range boundary (12 in range, 13 and 15 not).
        for (int i = 0; i < 6; i++) begin
            b_valid = 1'b1;
            b_cw    = bcw[i];
            @(posedge clk); #1;
            b_valid = 1'b0;
            @(posedge clk); #1;
            check("b_ovalid", i, 32'(b_o_valid), 32'd1);
            check("b_data",   i, 32'(b_data),    32'(bdat[i]));
            check("b_single", i, 32'(b_single),  32'(bsgl[i]));
            check("b_double", i, 32'(b_double),  32'(bdbl[i]));
            check("b_syn",    i, 32'(b_syn),     32'(bsyn[i]));
        end
        @(posedge clk); #1;
        check("b_sec",    0, 32'(b_sec), 32'd2);
        check("b_ded",    0, 32'(b_ded), 32'd3);
        check("b_sticky", 0, 32'({b_fv, b_fl, b_fs}), 32'({1'b1, 1'b0, 4'd12}));
        check("b_oready", 0, 32'(b_o_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
